// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: block geometry, padding constants, padder
// state encoding and the round constants used by the compression engine.
package sha256_pkg;

  localparam int BLOCK_W     = 512;
  localparam int LEN_FIELD_W = 64;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  // Highest byte index at which the 0x80 marker still leaves room for the
  // 8-byte length field in the same block.
  localparam logic [5:0] LAST_FIT_IDX = 6'd55;

  typedef enum logic [2:0] {
    FILL    = 3'd0,
    PAD     = 3'd1,
    PAD_LEN = 3'd2,
    EMIT    = 3'd3,
    ERR     = 3'd4
  } pad_state_t;

  localparam logic [31:0] H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sha256_pad_fill.sv
// Combinational padding of a partially filled block: keeps bytes below idx,
// optionally places the 0x80 marker at idx, zeroes the rest and inserts the
// big-endian bit length when it fits behind the marker.
module sha256_pad_fill
  import sha256_pkg::*;
(
  input  logic [BLOCK_W-1:0]     blk_i,
  input  logic [5:0]             idx_i,
  input  logic                   need80_i,
  input  logic [LEN_FIELD_W-1:0] len_i,
  output logic [BLOCK_W-1:0]     blk_o,
  output logic                   fits_len_o
);

  // Per-byte select between kept data, marker, zero and length field.
  always_comb begin
    fits_len_o = (idx_i <= LAST_FIT_IDX);
    blk_o      = '0;
    for (int b = 0; b < 64; b++) begin
      if (6'(b) < idx_i) begin
        blk_o[BLOCK_W-1-8*b -: 8] = blk_i[BLOCK_W-1-8*b -: 8];
      end else if ((6'(b) == idx_i) && need80_i) begin
        blk_o[BLOCK_W-1-8*b -: 8] = PAD_BYTE;
      end
      if (fits_len_o && (b >= 56)) begin
        blk_o[BLOCK_W-1-8*b -: 8] = len_i[8*(63-b) +: 8];
      end
    end
  end

endmodule

// File: rtl/sha256_block_padder.sv
// Byte-stream to padded 512-bit block converter feeding the SHA-256
// scheduler. Single block buffer: input stalls while a block is offered.
module sha256_block_padder
  import sha256_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic [BLOCK_W-1:0] blk_data,
  output logic               blk_first,
  output logic               blk_last,
  output logic               err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pad_state_t         state_q, state_d, ret_q, ret_d;
  logic [5:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               need80_q, need80_d;
  logic               last_q, last_d;
  logic               first_pend_q, first_pend_d;
  logic               err_q, err_d;
  logic               run_q;
  logic [BLOCK_W-1:0] blk_q, blk_d;

  logic               byte_xfer, blk_xfer, fits_len;
  logic [5:0]         fill_idx;
  logic               fill_need80;
  logic [LEN_FIELD_W-1:0] bit_len;
  logic [BLOCK_W-1:0] fill_blk;

  assign in_ready  = run_q && (state_q == FILL);
  assign blk_valid = (state_q == EMIT);
  assign blk_first = blk_valid && first_pend_q;
  assign blk_last  = blk_valid && last_q;
  assign blk_data  = blk_q;
  assign err       = err_q;

  assign byte_xfer = in_valid && in_ready;
  assign blk_xfer  = blk_valid && blk_ready;

  // The length-only block reuses the filler with an empty prefix and no marker.
  assign fill_idx    = (state_q == PAD_LEN) ? 6'd0 : idx_q;
  assign fill_need80 = (state_q == PAD) && need80_q;
  assign bit_len     = LEN_FIELD_W'({cnt_q, 3'b000});

  sha256_pad_fill u_fill (
    .blk_i      (blk_q),
    .idx_i      (fill_idx),
    .need80_i   (fill_need80),
    .len_i      (bit_len),
    .blk_o      (fill_blk),
    .fits_len_o (fits_len)
  );

  // State and datapath registers; run_q holds off in_ready for the reset cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= FILL;
      ret_q        <= FILL;
      idx_q        <= '0;
      cnt_q        <= '0;
      need80_q     <= 1'b0;
      last_q       <= 1'b0;
      first_pend_q <= 1'b1;
      err_q        <= 1'b0;
      run_q        <= 1'b0;
      blk_q        <= '0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      need80_q     <= need80_d;
      last_q       <= last_d;
      first_pend_q <= first_pend_d;
      err_q        <= err_d;
      run_q        <= 1'b1;
      blk_q        <= blk_d;
    end
  end

  // Next-state logic: fill bytes, pad, emit, and trap length overflow.
  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    need80_d     = need80_q;
    last_d       = last_q;
    first_pend_d = first_pend_q;
    err_d        = err_q;
    blk_d        = blk_q;
    unique case (state_q)
      FILL: begin
        if (byte_xfer) begin
          if ((cnt_q == CNT_MAX) && !in_last) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
            blk_d[{6'd63 - idx_q, 3'b000} +: 8] = in_data;
            idx_d = idx_q + 6'd1;
            cnt_d = cnt_q + CNT_W'(1);
            if (idx_q == 6'd63) begin
              state_d  = EMIT;
              last_d   = 1'b0;
              need80_d = in_last;
              ret_d    = in_last ? PAD : FILL;
            end else if (in_last) begin
              state_d  = PAD;
              need80_d = 1'b1;
            end
          end
        end
      end
      PAD: begin
        blk_d   = fill_blk;
        state_d = EMIT;
        last_d  = fits_len;
        ret_d   = fits_len ? FILL : PAD_LEN;
      end
      PAD_LEN: begin
        blk_d   = fill_blk;
        state_d = EMIT;
        last_d  = 1'b1;
        ret_d   = FILL;
      end
      EMIT: begin
        if (blk_xfer) begin
          state_d      = ret_q;
          first_pend_d = last_q;
          if (last_q) begin
            idx_d    = '0;
            cnt_d    = '0;
            need80_d = 1'b0;
          end
        end
      end
      ERR: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

endmodule

// File: tb/tb_sha256_block_padder.sv
// Bench for sha256_block_padder: directed scenarios plus randomized messages
// checked against a byte-queue padding model.
module tb_sha256_block_padder;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0, in_last = 1'b0, blk_ready = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_ready, blk_valid, blk_first, blk_last, err;
  logic [511:0] blk_data;

  logic         s_reset = 1'b1;
  logic         s_valid = 1'b0, s_last = 1'b0, s_blk_ready = 1'b0;
  logic         s_in_ready, s_blk_valid, s_blk_first, s_blk_last, s_err;
  logic [511:0] s_blk_data;

  int total = 0;
  int bad   = 0;
  logic [7:0]   msg_q[$];
  logic [511:0] exp_q[$];

  always #5 clock = ~clock;

  sha256_block_padder #(.CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last), .err(err)
  );

  sha256_block_padder #(.CNT_W(4)) dut_small (
    .clock(clock), .reset(s_reset),
    .in_valid(s_valid), .in_ready(s_in_ready), .in_data(in_data), .in_last(s_last),
    .blk_valid(s_blk_valid), .blk_ready(s_blk_ready), .blk_data(s_blk_data),
    .blk_first(s_blk_first), .blk_last(s_blk_last), .err(s_err)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference padding: append 0x80, zero-fill to 56 mod 64, append 64-bit
  // big-endian bit length, then slice into 64-byte blocks.
  function automatic void model();
    logic [7:0]   p[$];
    logic [63:0]  len;
    logic [511:0] b;
    p = msg_q;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    len = 64'(msg_q.size()) << 3;
    for (int k = 7; k >= 0; k--) p.push_back(len[8*k +: 8]);
    exp_q.delete();
    for (int blk = 0; blk < p.size() / 64; blk++) begin
      b = '0;
      for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[64*blk + j];
      exp_q.push_back(b);
    end
  endfunction

  task automatic set_inc(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'(i));
  endtask

  task automatic set_abc();
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_blk_valid", blk_valid, 0);
    check("rst_blk_data", blk_data, 0);
    check("rst_first", blk_first, 0);
    check("rst_last", blk_last, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    check("rst_rel_ready_lo", in_ready, 0);
    @(posedge clock); #1;
    check("rst_rel_ready_hi", in_ready, 1);
  endtask

  // Drive msg_q back-to-back; returns right after the final byte is taken.
  task automatic feed(input string tag, input bit with_last);
    int i = 0;
    int guard = 0;
    bit xfer;
    while (i < msg_q.size() && guard < 2000) begin
      in_valid = 1'b1;
      in_data  = msg_q[i];
      in_last  = with_last && (i == msg_q.size() - 1);
      xfer     = in_ready;
      @(posedge clock); #1;
      if (xfer) i++;
      guard++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    check({tag, "_fed"}, i, msg_q.size());
  endtask

  task automatic wait_blk(output int lat);
    lat = 1;
    while (!blk_valid && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic take(input string tag, input int k);
    check({tag, "_valid"}, blk_valid, 1);
    check({tag, "_data"}, blk_data, exp_q[k]);
    check({tag, "_first"}, blk_first, (k == 0));
    check({tag, "_last"}, blk_last, (k == exp_q.size() - 1));
    blk_ready = 1'b1;
    @(posedge clock); #1;
    blk_ready = 1'b0;
  endtask

  // Random valid gaps and backpressure, stray in_last while idle.
  task automatic run_msg(input string tag);
    int bi = 0, ki = 0, cyc = 0, n;
    bit held = 0;
    logic [511:0] hold;
    model();
    n = exp_q.size();
    while (ki < n && cyc < 20000) begin
      in_valid  = (bi < msg_q.size()) && ($urandom_range(3) != 0);
      in_data   = in_valid ? msg_q[bi] : 8'($urandom);
      in_last   = in_valid ? (bi == msg_q.size() - 1) : 1'($urandom_range(1));
      blk_ready = ($urandom_range(2) != 0);
      if (held) check({tag, "_hold"}, blk_data, hold);
      held = 0;
      if (blk_valid) begin
        check({tag, "_rdy_lo"}, in_ready, 0);
        if (blk_ready) begin
          check({tag, "_data"}, blk_data, exp_q[ki]);
          check({tag, "_first"}, blk_first, (ki == 0));
          check({tag, "_last"}, blk_last, (ki == n - 1));
          ki++;
        end else begin
          hold = blk_data;
          held = 1;
        end
      end
      if (in_valid && in_ready) bi++;
      @(posedge clock); #1;
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b0;
    check({tag, "_blocks"}, ki, n);
    check({tag, "_bytes"}, bi, msg_q.size());
  endtask

  initial begin
    int lat;
    logic [511:0] hold;
    int lens[$];

    do_reset();

    // "abc"
    set_abc(); model();
    feed("abc", 1); wait_blk(lat);
    check("abc_lat", lat, 2);
    check("abc_head", blk_data[511:480], 32'h61626380);
    check("abc_len", blk_data[63:0], 64'h18);
    take("abc", 0);

    // 55 bytes: marker at byte 55 still fits
    set_inc(55); model();
    feed("m55", 1); wait_blk(lat);
    check("m55_lat", lat, 2);
    check("m55_80", blk_data[71:64], 8'h80);
    check("m55_len", blk_data[63:0], 64'h1B8);
    take("m55", 0);

    // 56 bytes: length spills into a second block
    set_inc(56); model();
    feed("m56", 1); wait_blk(lat);
    check("m56_lat", lat, 2);
    check("m56_80", blk_data[63:56], 8'h80);
    take("m56b0", 0);
    wait_blk(lat);
    check("m56_lat2", lat, 2);
    check("m56_len", blk_data[63:0], 64'h1C0);
    take("m56b1", 1);

    // 64 bytes: raw block, then marker-and-length block
    set_inc(64); model();
    feed("m64", 1); wait_blk(lat);
    check("m64_lat", lat, 1);
    take("m64b0", 0);
    wait_blk(lat);
    check("m64_lat2", lat, 2);
    check("m64_80", blk_data[511:504], 8'h80);
    check("m64_len", blk_data[63:0], 64'h200);
    take("m64b1", 1);

    // Backpressure on "abc", then a back-to-back second message
    set_abc(); model();
    feed("bp", 1); wait_blk(lat);
    hold = blk_data;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", blk_valid, 1);
      check("bp_ready_lo", in_ready, 0);
      check("bp_stable", blk_data, hold);
      @(posedge clock); #1;
    end
    take("bp", 0);
    check("bp_ready_back", in_ready, 1);
    feed("bp2", 1); wait_blk(lat);
    take("bp2", 0);

    // Reset in the middle of a message
    set_inc(30);
    feed("mid", 0);
    #2 reset = 1'b1;
    #1;
    check("mid_in_ready", in_ready, 0);
    check("mid_blk_valid", blk_valid, 0);
    check("mid_blk_data", blk_data, 0);
    check("mid_first", blk_first, 0);
    check("mid_last", blk_last, 0);
    check("mid_err", err, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check("mid_idle", blk_valid, 0);
    set_abc(); model();
    feed("abc2", 1); wait_blk(lat);
    check("abc2_lat", lat, 2);
    take("abc2", 0);

    // Randomized messages, boundary lengths first
    lens = '{1, 54, 55, 56, 57, 63, 64, 65, 119, 120, 127, 128, 129};
    for (int r = 0; r < 12; r++) lens.push_back($urandom_range(200, 1));
    foreach (lens[m]) begin
      msg_q.delete();
      for (int i = 0; i < lens[m]; i++) msg_q.push_back(8'($urandom));
      run_msg($sformatf("rnd%0d_len%0d", m, lens[m]));
    end

    // Small counter: 16 bytes without in_last overflows
    s_reset = 1'b0;
    @(posedge clock); #1;
    check("ovf_ready_hi", s_in_ready, 1);
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_last = 1'b0; in_data = 8'(i);
      @(posedge clock); #1;
    end
    check("ovf_err", s_err, 1);
    for (int c = 0; c < 4; c++) begin
      check("ovf_ready_lo", s_in_ready, 0);
      check("ovf_blk_valid", s_blk_valid, 0);
      check("ovf_err_sticky", s_err, 1);
      @(posedge clock); #1;
    end
    s_valid = 1'b0;
    s_reset = 1'b1;
    #1;
    check("ovf_err_clr", s_err, 0);
    @(posedge clock); #1;
    s_reset = 1'b0;
    @(posedge clock); #1;

    // Small counter: maximum-length message of 15 bytes is legal
    set_inc(15); model();
    for (int i = 0; i < 15; i++) begin
      s_valid = 1'b1; s_last = (i == 14); in_data = msg_q[i];
      @(posedge clock); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
    lat = 1;
    while (!s_blk_valid && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    check("max_lat", lat, 2);
    check("max_data", s_blk_data, exp_q[0]);
    check("max_len", s_blk_data[63:0], 64'h78);
    check("max_last", s_blk_last, 1);
    check("max_err", s_err, 0);
    s_blk_ready = 1'b1;
    @(posedge clock); #1;
    s_blk_ready = 1'b0;
    check("max_done", s_blk_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
